// File: rtl/ring_osc_ctrl.sv
// -----------------------------------------------------------------------------
// ring_osc_ctrl
//
// Purpose:
//   Synchronous sequencer/monitor for one NCL dual-rail oscillation ring.
//   Holds the ring in its initial wavefront pattern, releases it, ignores
//   start-up glitches for a settle window, then counts wavefronts seen on one
//   asynchronous completion tap, measures the edge-to-edge period in clk
//   cycles and detects stalls. A stall triggers a bounded number of automatic
//   re-inits before the controller parks in FAULT.
//
// Optional feature (compile-time macro RING_OSC_CTRL_AVG_EN):
//   When defined, o_period reports the mean of the last 4 intervals and
//   o_period_valid only pulses once 4 intervals exist since RUN entry.
//   When undefined, o_period is the most recent single interval.
//
// Ports:
//   i_clk          system clock
//   i_init         asynchronous active-high reset
//   i_start        level; begin a run (honoured in IDLE only)
//   i_stop         level; abort to IDLE from any state, beats i_start
//   i_tap_comp     asynchronous completion tap from one ring stage
//   o_ring_init    ring init line; high holds the ring in its initial pattern
//   o_running      high while in RUN
//   o_stall        one-cycle pulse per timeout detection
//   o_fault        high while in FAULT
//   o_wave_count   tap rising edges counted in RUN (wraps)
//   o_period       last measured interval (or 4-interval mean) in clk cycles
//   o_period_valid one-cycle pulse when o_period updates
//   o_retries      re-init attempts since the last start (saturating)
// -----------------------------------------------------------------------------
module ring_osc_ctrl #(
    parameter int unsigned INIT_CYCLES   = 20,  // must be >= 1
    parameter int unsigned SETTLE_CYCLES = 8,   // must be >= 1
    parameter int unsigned TIMEOUT       = 255,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned MAX_RETRY     = 3    // must fit in 2 bits
) (
    input  logic             i_clk,
    input  logic             i_init,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_tap_comp,
    output logic             o_ring_init,
    output logic             o_running,
    output logic             o_stall,
    output logic             o_fault,
    output logic [CNT_W-1:0] o_wave_count,
    output logic [CNT_W-1:0] o_period,
    output logic             o_period_valid,
    output logic [1:0]       o_retries
);

    localparam int unsigned PH_MAX = (INIT_CYCLES > SETTLE_CYCLES) ? INIT_CYCLES : SETTLE_CYCLES;
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StSettle,
        StRun,
        StFault
    } state_t;

    state_t r_state, w_state_next;

    // Tap synchroniser (2 flops), delayed copy for edge detect, registered edge.
    logic r_sync1, r_sync2, r_sync3, r_edge;

    logic [PH_W-1:0]  r_ph,       w_ph_next;
    logic [TMO_W-1:0] r_tmo,      w_tmo_next;
    logic [CNT_W-1:0] r_per_cnt,  w_per_cnt_next;
    logic             r_first,    w_first_next;
    logic [CNT_W-1:0] r_wave,     w_wave_next;
    logic [CNT_W-1:0] r_period,   w_period_next;
    logic             r_pv,       w_pv_next;
    logic             r_stall,    w_stall_next;
    logic [1:0]       r_retries,  w_retries_next;
    logic             r_ring_init, w_ring_init_next;
    logic             r_running,  w_running_next;
    logic             r_fault,    w_fault_next;

`ifdef RING_OSC_CTRL_AVG_EN
    logic [CNT_W-1:0] r_buf [4];
    logic [CNT_W-1:0] w_buf_next [4];
    logic [CNT_W+1:0] r_acc, w_acc_next;
    // Number of intervals captured since RUN entry, saturating at 3 ("3 or more").
    logic [1:0]       r_ncap, w_ncap_next;
`endif

    // -------------------------------------------------------------------------
    // Tap synchroniser and rising-edge detector
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_init) begin
        if (i_init) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
            r_edge  <= 1'b0;
        end else begin
            r_sync1 <= i_tap_comp;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_edge  <= r_sync2 & ~r_sync3;
        end
    end

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_init) begin
        if (i_init) begin
            r_state     <= StIdle;
            r_ph        <= '0;
            r_tmo       <= '0;
            r_per_cnt   <= '0;
            r_first     <= 1'b0;
            r_wave      <= '0;
            r_period    <= '0;
            r_pv        <= 1'b0;
            r_stall     <= 1'b0;
            r_retries   <= '0;
            r_ring_init <= 1'b1;
            r_running   <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_ph        <= w_ph_next;
            r_tmo       <= w_tmo_next;
            r_per_cnt   <= w_per_cnt_next;
            r_first     <= w_first_next;
            r_wave      <= w_wave_next;
            r_period    <= w_period_next;
            r_pv        <= w_pv_next;
            r_stall     <= w_stall_next;
            r_retries   <= w_retries_next;
            r_ring_init <= w_ring_init_next;
            r_running   <= w_running_next;
            r_fault     <= w_fault_next;
        end
    end

`ifdef RING_OSC_CTRL_AVG_EN
    always_ff @(posedge i_clk or posedge i_init) begin
        if (i_init) begin
            for (int i = 0; i < 4; i++) begin
                r_buf[i] <= '0;
            end
            r_acc  <= '0;
            r_ncap <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                r_buf[i] <= w_buf_next[i];
            end
            r_acc  <= w_acc_next;
            r_ncap <= w_ncap_next;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_ph_next      = r_ph;
        w_tmo_next     = r_tmo;
        w_per_cnt_next = r_per_cnt;
        w_first_next   = r_first;
        w_wave_next    = r_wave;
        w_period_next  = r_period;
        w_pv_next      = 1'b0;
        w_stall_next   = 1'b0;
        w_retries_next = r_retries;
`ifdef RING_OSC_CTRL_AVG_EN
        w_buf_next  = r_buf;
        w_acc_next  = r_acc;
        w_ncap_next = r_ncap;
`endif

        if (i_stop) begin
            w_state_next = StIdle;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        w_state_next   = StInit;
                        w_ph_next      = '0;
                        w_wave_next    = '0;
                        w_period_next  = '0;
                        w_retries_next = '0;
                    end
                end

                StInit: begin
                    if (r_ph == PH_W'(INIT_CYCLES - 1)) begin
                        w_state_next = StSettle;
                        w_ph_next    = '0;
                    end else begin
                        w_ph_next = r_ph + PH_W'(1);
                    end
                end

                StSettle: begin
                    // Tap edges here are start-up artefacts and are dropped.
                    if (r_ph == PH_W'(SETTLE_CYCLES - 1)) begin
                        w_state_next   = StRun;
                        w_ph_next      = '0;
                        w_tmo_next     = '0;
                        w_per_cnt_next = '0;
                        w_first_next   = 1'b0;
`ifdef RING_OSC_CTRL_AVG_EN
                        for (int i = 0; i < 4; i++) begin
                            w_buf_next[i] = '0;
                        end
                        w_acc_next  = '0;
                        w_ncap_next = '0;
`endif
                    end else begin
                        w_ph_next = r_ph + PH_W'(1);
                    end
                end

                StRun: begin
                    // Period counter only runs once the first edge has been seen.
                    if (r_first && (r_per_cnt != '1)) begin
                        w_per_cnt_next = r_per_cnt + CNT_W'(1);
                    end

                    if (r_edge) begin
                        // An edge coinciding with timeout expiry wins: no stall.
                        w_wave_next    = r_wave + CNT_W'(1);
                        w_tmo_next     = '0;
                        w_per_cnt_next = CNT_W'(1);
                        if (!r_first) begin
                            w_first_next = 1'b1;
                        end else begin
`ifdef RING_OSC_CTRL_AVG_EN
                            // Running sum: add newest interval, drop the oldest.
                            w_buf_next[0] = r_per_cnt;
                            for (int i = 1; i < 4; i++) begin
                                w_buf_next[i] = r_buf[i-1];
                            end
                            w_acc_next = r_acc + {2'b00, r_per_cnt} - {2'b00, r_buf[3]};
                            if (r_ncap == 2'd3) begin
                                w_period_next = w_acc_next[CNT_W+1:2];
                                w_pv_next     = 1'b1;
                            end else begin
                                w_ncap_next = r_ncap + 2'd1;
                            end
`else
                            w_period_next = r_per_cnt;
                            w_pv_next     = 1'b1;
`endif
                        end
                    end else if (r_tmo == TMO_W'(TIMEOUT)) begin
                        w_stall_next = 1'b1;
                        if (r_retries < 2'(MAX_RETRY)) begin
                            w_retries_next = r_retries + 2'd1;
                            w_state_next   = StInit;
                            w_ph_next      = '0;
                        end else begin
                            w_state_next = StFault;
                        end
                    end else begin
                        w_tmo_next = r_tmo + TMO_W'(1);
                    end
                end

                StFault: begin
                    // Parked until i_stop, handled above.
                end

                default: begin
                    w_state_next = StIdle;
                end
            endcase
        end

        // Level outputs are registered copies of the next-state decode so the
        // ring init line is glitch-free.
        w_ring_init_next = (w_state_next == StIdle) || (w_state_next == StInit) ||
                           (w_state_next == StFault);
        w_running_next   = (w_state_next == StRun);
        w_fault_next     = (w_state_next == StFault);
    end

    assign o_ring_init    = r_ring_init;
    assign o_running      = r_running;
    assign o_stall        = r_stall;
    assign o_fault        = r_fault;
    assign o_wave_count   = r_wave;
    assign o_period       = r_period;
    assign o_period_valid = r_pv;
    assign o_retries      = r_retries;

endmodule

// File: tb/tb_ring_osc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ring_osc_ctrl
//
// Directed self-checking bench for ring_osc_ctrl (default parameters).
// Expected values are hand-derived from the controller's timing: tap edges are
// acted on 4 clk edges after the tap is driven high, RUN is entered 28 cycles
// after the start edge, and a stall is flagged 256 cycles after the last
// timeout-counter clear. Honours RING_OSC_CTRL_AVG_EN for the period checks.
// -----------------------------------------------------------------------------
module tb_ring_osc_ctrl;

    localparam int unsigned CNT_W = 16;

    logic             clk;
    logic             init;
    logic             start;
    logic             stop;
    logic             tap;
    logic             ring_init;
    logic             running;
    logic             stall;
    logic             fault;
    logic [CNT_W-1:0] wave_count;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic [1:0]       retries;

    int checks = 0;
    int errors = 0;
    int pv_cnt = 0;
    int stall_cnt = 0;
    logic [31:0] pv_q [$];
    int exp_p [$];
    int gaps [$];
    int n;
    int stall_snap;

    ring_osc_ctrl dut (
        .i_clk          (clk),
        .i_init         (init),
        .i_start        (start),
        .i_stop         (stop),
        .i_tap_comp     (tap),
        .o_ring_init    (ring_init),
        .o_running      (running),
        .o_stall        (stall),
        .o_fault        (fault),
        .o_wave_count   (wave_count),
        .o_period       (period),
        .o_period_valid (period_valid),
        .o_retries      (retries)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n clocks, sampling 1ns after each rising edge.
    task automatic tick(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            if (period_valid) begin
                pv_cnt++;
                pv_q.push_back(32'(period));
            end
            if (stall) stall_cnt++;
        end
    endtask

    task automatic wait_stall(input int bound, output int cnt);
        cnt = 0;
        while (!stall && cnt < bound) begin
            tick(1);
            cnt++;
        end
    endtask

    // Called right after the edge that enters INIT.
    task automatic check_init_seq();
        for (int i = 1; i <= 28; i++) begin
            tick(1);
            check("init_seq_ring_init", 32'(ring_init), 32'(i < 20));
            check("init_seq_running", 32'(running), 32'(i >= 28));
            if (i == 1) check("stall_one_cycle", 32'(stall), 0);
        end
    endtask

    initial begin
        init  = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        tap   = 1'b0;
        tick(5);

        // Reset state
        check("rst_ring_init", 32'(ring_init), 1);
        check("rst_running", 32'(running), 0);
        check("rst_stall", 32'(stall), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_wave", 32'(wave_count), 0);
        check("rst_period", 32'(period), 0);
        check("rst_pv", 32'(period_valid), 0);
        check("rst_retries", 32'(retries), 0);

        init = 1'b0;
        tick(1);

        // Start: INIT 20 cycles, SETTLE 8, RUN on the 29th
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("start_ring_init", 32'(ring_init), 1);
        check("start_running", 32'(running), 0);
        check_init_seq();

        // 5 rising tap edges 40 clk apart
        pv_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tap = 1'b1;
            tick(20);
            tap = 1'b0;
            tick(20);
        end
        check("run_wave", 32'(wave_count), 5);
        check("run_period", 32'(period), 40);
`ifdef RING_OSC_CTRL_AVG_EN
        check("run_pv_count", 32'(pv_cnt), 1);
`else
        check("run_pv_count", 32'(pv_cnt), 4);
`endif
        check("run_no_stall", 32'(stall_cnt), 0);
        check("run_running", 32'(running), 1);

        // Stall 1: last edge acted on 36 cycles ago
        wait_stall(400, n);
        check("stall1_latency", 32'(n), 220);
        check("stall1_pulse", 32'(stall), 1);
        check("stall1_retries", 32'(retries), 1);
        check("stall1_ring_init", 32'(ring_init), 1);
        check("stall1_running", 32'(running), 0);
        check_init_seq();

        // Edge lands exactly on the timeout cycle: counted, no stall
        stall_snap = stall_cnt;
        tick(252);
        tap = 1'b1;
        tick(4);
        check("tmo_edge_no_stall", 32'(stall_cnt - stall_snap), 0);
        check("tmo_edge_wave", 32'(wave_count), 6);
        check("tmo_edge_running", 32'(running), 1);
        check("tmo_edge_period_held", 32'(period), 40);
        tap = 1'b0;

        // Stall 2
        wait_stall(400, n);
        check("stall2_latency", 32'(n), 256);
        check("stall2_retries", 32'(retries), 2);
        check_init_seq();

        // Stall 3
        wait_stall(400, n);
        check("stall3_latency", 32'(n), 256);
        check("stall3_retries", 32'(retries), 3);
        check("stall3_fault", 32'(fault), 0);
        check_init_seq();

        // Stall 4: retries exhausted, FAULT
        wait_stall(400, n);
        check("stall4_latency", 32'(n), 256);
        check("stall4_fault", 32'(fault), 1);
        check("stall4_ring_init", 32'(ring_init), 1);
        check("stall4_running", 32'(running), 0);
        check("stall4_retries", 32'(retries), 3);
        tick(5);
        check("fault_hold", 32'(fault), 1);
        check("fault_stall_low", 32'(stall), 0);
        check("fault_ring_init", 32'(ring_init), 1);

        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        check("stop_fault_clr", 32'(fault), 0);
        check("stop_ring_init", 32'(ring_init), 1);

        // start and stop together: stop wins, nothing cleared
        start = 1'b1;
        stop  = 1'b1;
        tick(1);
        start = 1'b0;
        stop  = 1'b0;
        tick(3);
        check("ss_ring_init", 32'(ring_init), 1);
        check("ss_running", 32'(running), 0);
        check("ss_retries_kept", 32'(retries), 3);
        check("ss_wave_kept", 32'(wave_count), 6);
        check("ss_period_kept", 32'(period), 40);

        // Fresh start clears results
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("restart_retries", 32'(retries), 0);
        check("restart_wave", 32'(wave_count), 0);
        check("restart_period", 32'(period), 0);
        check_init_seq();

        // Varying intervals 40, 44, 36, 40, 60
        gaps = '{40, 44, 36, 40, 60, 20};
`ifdef RING_OSC_CTRL_AVG_EN
        exp_p = '{40, 45};
`else
        exp_p = '{40, 44, 36, 40, 60};
`endif
        pv_q.delete();
        foreach (gaps[i]) begin
            tap = 1'b1;
            tick(gaps[i] / 2);
            tap = 1'b0;
            tick(gaps[i] - gaps[i] / 2);
        end
        check("var_wave", 32'(wave_count), 6);
        check("var_pv_count", 32'(pv_q.size()), 32'(exp_p.size()));
        foreach (exp_p[i]) begin
            check("var_period", (i < pv_q.size()) ? pv_q[i] : 32'hFFFF_FFFF, 32'(exp_p[i]));
        end

        // Asynchronous init mid-RUN
        check("pre_init_running", 32'(running), 1);
        #3;
        init = 1'b1;
        #1;
        check("ainit_ring_init", 32'(ring_init), 1);
        check("ainit_running", 32'(running), 0);
        check("ainit_wave", 32'(wave_count), 0);
        check("ainit_period", 32'(period), 0);
        check("ainit_retries", 32'(retries), 0);
        check("ainit_fault", 32'(fault), 0);
        tick(2);
        init = 1'b0;
        tick(2);
        check("post_init_idle", 32'(ring_init), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ring_osc_ctrl.md
Name: ring_osc_ctrl

Overview:
- Synchronous controller that sequences and monitors one NCL dual-rail oscillation ring.
- Drives the ring's init line with a programmable hold pulse and samples one asynchronous completion tap from the ring.
- Counts wavefronts, measures oscillation period in clk cycles, and detects stalls, with automatic bounded re-init.
- Sits between the ring instance and the test/characterisation harness.

Parameters:
- INIT_CYCLES, 20: clk cycles ring_init is held high in INIT before release.
- SETTLE_CYCLES, 8: clk cycles after release during which tap edges are ignored.
- TIMEOUT, 255: clk cycles in RUN with no tap edge before declaring a stall.
- CNT_W, 16: width of wave_count and period.
- MAX_RETRY, 3: automatic re-init attempts before FAULT.

Ports:
- clk  in  1  system clock.
- init  in  1  asynchronous active-high reset.
- start  in  1  level; begin a ring run (sampled in IDLE only).
- stop  in  1  level; abort to IDLE from any state.
- tap_comp  in  1  asynchronous completion signal from one ring stage.
- ring_init  out  1  init line to all ring stages; high holds the ring in its initial wavefront pattern.
- running  out  1  high while in RUN.
- stall  out  1  one-cycle pulse on each timeout detection.
- fault  out  1  high while in FAULT.
- wave_count  out  CNT_W  tap rising edges counted in RUN; wraps.
- period  out  CNT_W  last measured edge-to-edge interval in clk cycles.
- period_valid  out  1  one-cycle pulse when period updates.
- retries  out  2  re-init attempts since the last start.

Behaviour:
- Reset (init high, asynchronous):
  - ring_init=1; all other outputs 0.
  - FSM=IDLE; synchroniser flops cleared.
- tap_comp path:
  - Passes through a 2-flop synchroniser, then a rising-edge detector.
  - edge pulse occurs 3 clk after the tap rises.
- FSM states: IDLE, INIT, SETTLE, RUN, FAULT.
  - IDLE: ring_init=1. If start=1 and stop=0: go to INIT and clear wave_count, period and retries.
  - INIT: ring_init=1 for exactly INIT_CYCLES cycles, then go to SETTLE.
  - SETTLE: ring_init=0. Edges are ignored for SETTLE_CYCLES cycles, then go to RUN. The timeout counter is cleared on RUN entry.
  - RUN: ring_init=0, running=1.
    - On edge: wave_count+1 (modulo 2^CNT_W) and timeout counter cleared.
    - The first edge after RUN entry only starts the period counter.
    - Each later edge loads period with the counter value, pulses period_valid, and restarts the counter.
    - The period counter saturates at 2^CNT_W-1.
  - Stall: the timeout counter reaches TIMEOUT with no edge in that cycle.
    - stall pulses once.
    - If retries < MAX_RETRY: retries+1, go to INIT.
    - Otherwise go to FAULT.
  - FAULT: ring_init=1, fault=1. Stays until stop=1, then goes to IDLE.
- stop=1 in any state → IDLE on the next edge; ring_init=1 from that cycle. stop beats start when both are high.
- start is ignored outside IDLE.
- An edge in the same cycle as timeout expiry counts as an edge; no stall is raised.
- retries saturates at MAX_RETRY. It is cleared only on a new start from IDLE or on reset.
- wave_count and period hold their values across INIT/SETTLE re-entries and in IDLE/FAULT, so results stay readable after a run.
- Asserting init mid-run returns everything to reset values immediately; ring_init rises asynchronously.

Optional Feature:
- Macro: RING_OSC_CTRL_AVG_EN.
- Defined:
  - period reports the mean of the last 4 intervals: a 4-entry shift buffer summed into a CNT_W+2-bit accumulator, right-shifted by 2.
  - period_valid pulses only once 4 intervals have been captured since RUN entry, then on every later interval.
  - The buffer is cleared on every RUN entry.
- Undefined: period is the single most recent interval, as described above.

Test Plan:
- Hold init 5 cycles, release, start=1 → ring_init held high for 20 cycles after INIT entry, then low for 8 SETTLE cycles; running=1 on cycle 29.
- In RUN, toggle tap_comp high every 40 clk, 5 rising edges → wave_count=5; period_valid pulses 4 times; period=40.
- In RUN, stop tap toggling → stall pulses after 255 idle cycles, retries=1, ring_init high again for 20 cycles.
- Never toggle the tap across runs → 3 stalls re-init; the 4th stall → fault=1, ring_init=1. Then stop=1 → IDLE, fault=0.
- Raise start and stop in the same IDLE cycle → stays IDLE, ring_init=1. Assert init mid-RUN → all outputs 0 and ring_init=1 asynchronously.
- With RING_OSC_CTRL_AVG_EN, tap intervals 40, 44, 36, 40, 60 → first period_valid on the 5th edge with period=40; next valid reports 45.
